// File: rtl/balanca_tara_media_if.sv
// balanca_tara_media_if: sample, tare-request and net-weight signals of the scale stage
interface balanca_tara_media_if #(parameter int LARGURA = 16);
  logic               amostra_valida;
  logic [LARGURA-1:0] entrada;
  logic               tarar;
  logic               zerar_tara;
  logic [LARGURA-1:0] resultado;
  logic               resultado_valido;
  logic               negativo;
  logic               estavel;
  logic [LARGURA-1:0] tara_atual;
  logic               ocupado;
  logic               tara_erro;
  modport master (
    output amostra_valida, entrada, tarar, zerar_tara,
    input  resultado, resultado_valido, negativo, estavel, tara_atual, ocupado, tara_erro
  );
  modport slave (
    input  amostra_valida, entrada, tarar, zerar_tara,
    output resultado, resultado_valido, negativo, estavel, tara_atual, ocupado, tara_erro
  );
endinterface

// File: rtl/balanca_tara_media.sv
// balanca_tara_media: moving-average scale with stability detect and tare capture; BALANCA_SATURA_EN clamps negative net weight to 0
module balanca_tara_media #(
  parameter int LARGURA        = 16,
  parameter int LOG2_PROF      = 3,
  parameter int LIMIAR         = 4,
  parameter int CICLOS_ESTAVEL = 4,
  parameter int TIMEOUT        = 64
) (
  input logic clk,
  input logic rst_n,
  balanca_tara_media_if.slave bus
);
  localparam int PROF = 1 << LOG2_PROF;
  localparam int SW   = LARGURA + LOG2_PROF;
  localparam int CW   = $clog2(CICLOS_ESTAVEL + 1);
  localparam int TW   = $clog2(TIMEOUT + 1);
  localparam logic [LOG2_PROF:0]   CHEIO   = (LOG2_PROF + 1)'(PROF);
  localparam logic [CW-1:0]        EST_MAX = CW'(CICLOS_ESTAVEL);
  localparam logic [TW-1:0]        TO_MAX  = TW'(TIMEOUT);
  localparam logic [LARGURA-1:0]   LIM     = LARGURA'(LIMIAR);
  typedef enum logic [1:0] {OCIOSO, AGUARDA, CAPTURA} estado_t;
  logic [LARGURA-1:0] amostras [PROF];
  logic [LOG2_PROF-1:0] ptr;
  logic [LOG2_PROF:0] cheios;
  logic [SW-1:0] soma, soma_nova;
  logic [LARGURA-1:0] media, media_nova, desvio, saida;
  logic [LARGURA:0] liquido;
  logic [CW-1:0] cont_est;
  logic [TW-1:0] cont_to, cont_to_next;
  estado_t estado, estado_next;
  logic cheio, estavel_int, erro_next;
  assign cheio       = cheios == CHEIO;
  assign soma_nova   = soma + SW'(bus.entrada) - SW'(amostras[ptr]);
  assign media       = soma[SW-1:LOG2_PROF];
  assign media_nova  = soma_nova[SW-1:LOG2_PROF];
  assign desvio      = bus.entrada >= media ? bus.entrada - media : media - bus.entrada;
  assign liquido     = {1'b0, media_nova} - {1'b0, bus.tara_atual};
  assign estavel_int = cheio && cont_est == EST_MAX;
  assign bus.estavel = estavel_int;
  assign bus.ocupado = estado != OCIOSO;
`ifdef BALANCA_SATURA_EN
  assign saida = liquido[LARGURA] ? '0 : liquido[LARGURA-1:0];
`else
  assign saida = liquido[LARGURA-1:0];
`endif
  // sample buffer, running sum, stability counter and net-weight output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PROF; i++) amostras[i] <= '0;
      ptr                  <= '0;
      cheios               <= '0;
      soma                 <= '0;
      cont_est             <= '0;
      bus.resultado        <= '0;
      bus.resultado_valido <= 1'b0;
      bus.negativo         <= 1'b0;
    end else begin
      bus.resultado_valido <= 1'b0;
      if (bus.amostra_valida) begin
        amostras[ptr] <= bus.entrada;
        soma          <= soma_nova;
        ptr           <= ptr + 1'b1;
        if (!cheio) cheios <= cheios + 1'b1;
        if (cheio) cont_est <= desvio > LIM ? '0 : cont_est == EST_MAX ? cont_est : cont_est + 1'b1;
        if (cheio || cheios == CHEIO - 1'b1) begin
          bus.resultado_valido <= 1'b1;
          bus.resultado        <= saida;
          bus.negativo         <= liquido[LARGURA];
        end
      end
    end
  end
  // tare FSM next state: zero request overrides everything, timeout counts accepted samples while waiting
  always_comb begin
    estado_next  = estado;
    cont_to_next = cont_to;
    erro_next    = 1'b0;
    if (bus.zerar_tara) begin
      estado_next  = OCIOSO;
      cont_to_next = '0;
    end else begin
      case (estado)
        OCIOSO: if (bus.tarar) begin
          estado_next  = AGUARDA;
          cont_to_next = '0;
        end
        AGUARDA: if (estavel_int) estado_next = CAPTURA;
        else if (bus.amostra_valida) begin
          cont_to_next = cont_to + 1'b1;
          if (cont_to_next == TO_MAX) begin
            estado_next = OCIOSO;
            erro_next   = 1'b1;
          end
        end
        default: estado_next = OCIOSO;
      endcase
    end
  end
  // tare FSM state, timeout counter, stored tare and error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado         <= OCIOSO;
      cont_to        <= '0;
      bus.tara_erro  <= 1'b0;
      bus.tara_atual <= '0;
    end else begin
      estado         <= estado_next;
      cont_to        <= cont_to_next;
      bus.tara_erro  <= erro_next;
      bus.tara_atual <= bus.zerar_tara ? '0 : estado == CAPTURA ? media : bus.tara_atual;
    end
  end
endmodule

// File: tb/tb_balanca_tara_media.sv
// tb_balanca_tara_media: directed checks of averaging, stability, tare capture, timeout and reset
module tb_balanca_tara_media;
  logic clk, rst_n;
  int total, bad, n_erro;
  balanca_tara_media_if #(.LARGURA(16)) bi();
  balanca_tara_media dut (.clk(clk), .rst_n(rst_n), .bus(bi));
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  // counts tare-error pulses just after each edge
  always @(posedge clk) begin
    #1;
    if (bi.tara_erro) n_erro++;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded, got running expected finished");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic amostra(input logic [15:0] v);
    @(negedge clk);
    bi.amostra_valida = 1'b1;
    bi.entrada = v;
    @(negedge clk);
    bi.amostra_valida = 1'b0;
  endtask
  task automatic pulso_tarar();
    @(negedge clk);
    bi.tarar = 1'b1;
    @(negedge clk);
    bi.tarar = 1'b0;
  endtask
  task automatic pulso_zerar();
    @(negedge clk);
    bi.zerar_tara = 1'b1;
    @(negedge clk);
    bi.zerar_tara = 1'b0;
  endtask
  function automatic logic [39:0] saidas();
    return 40'({bi.resultado, bi.resultado_valido, bi.negativo, bi.estavel,
                bi.tara_atual, bi.ocupado, bi.tara_erro});
  endfunction
  initial begin
    total = 0;
    bad = 0;
    n_erro = 0;
    rst_n = 1'b0;
    bi.amostra_valida = 1'b0;
    bi.entrada = '0;
    bi.tarar = 1'b0;
    bi.zerar_tara = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", saidas(), 40'd0);
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      amostra(16'd100);
      check($sformatf("fill_strobe%0d", i), 40'(bi.resultado_valido), 40'(i == 8));
    end
    check("avg100", 40'(bi.resultado), 40'd100);
    check("avg100_neg", 40'(bi.negativo), 40'd0);
    repeat (3) amostra(16'd100);
    check("estavel_after3", 40'(bi.estavel), 40'd0);
    amostra(16'd100);
    check("estavel_after4", 40'(bi.estavel), 40'd1);
    pulso_tarar();
    check("ocupado_tare", 40'(bi.ocupado), 40'd1);
    for (int i = 0; i < 4 && bi.tara_atual !== 16'd100; i++) @(negedge clk);
    check("tara_captured", 40'(bi.tara_atual), 40'd100);
    check("ocupado_done", 40'(bi.ocupado), 40'd0);
    amostra(16'd100);
    check("net0_strobe", 40'(bi.resultado_valido), 40'd1);
    check("net0", 40'(bi.resultado), 40'd0);
    check("net0_neg", 40'(bi.negativo), 40'd0);
    repeat (8) amostra(16'd350);
    check("net250", 40'(bi.resultado), 40'd250);
    check("net250_neg", 40'(bi.negativo), 40'd0);
    repeat (8) amostra(16'd40);
`ifdef BALANCA_SATURA_EN
    check("net_negative", 40'(bi.resultado), 40'd0);
`else
    check("net_negative", 40'(bi.resultado), 40'h0FFC4);
`endif
    check("net_negative_neg", 40'(bi.negativo), 40'd1);
    pulso_tarar();
    for (int i = 1; i <= 63; i++) amostra((i % 2) ? 16'd1000 : 16'd0);
    check("timeout_ocupado63", 40'(bi.ocupado), 40'd1);
    check("timeout_erro63", 40'(n_erro), 40'd0);
    amostra(16'd0);
    check("timeout_erro64", 40'(n_erro), 40'd1);
    check("timeout_ocupado64", 40'(bi.ocupado), 40'd0);
    repeat (3) @(negedge clk);
    check("timeout_single_pulse", 40'(n_erro), 40'd1);
    check("timeout_tara_kept", 40'(bi.tara_atual), 40'd100);
    check("timeout_estavel", 40'(bi.estavel), 40'd0);
    @(negedge clk);
    bi.tarar = 1'b1;
    bi.zerar_tara = 1'b1;
    @(negedge clk);
    bi.tarar = 1'b0;
    bi.zerar_tara = 1'b0;
    check("zerar_wins_tara", 40'(bi.tara_atual), 40'd0);
    check("zerar_wins_state", 40'(bi.ocupado), 40'd0);
    pulso_tarar();
    check("aguarda_ocupado", 40'(bi.ocupado), 40'd1);
    amostra(16'd1000);
    amostra(16'd0);
    pulso_zerar();
    check("zerar_abort", 40'(bi.ocupado), 40'd0);
    repeat (2) @(negedge clk);
    check("zerar_abort_noerro", 40'(n_erro), 40'd1);
    pulso_tarar();
    amostra(16'd1000);
    check("pre_reset_ocupado", 40'(bi.ocupado), 40'd1);
    check("pre_reset_res", 40'(bi.resultado), 40'd500);
    #2 rst_n = 1'b0;
    #1 check("async_reset_aguarda", saidas(), 40'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) amostra(16'd200);
    #2 rst_n = 1'b0;
    #1 check("async_reset_fill", saidas(), 40'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      amostra(16'd200);
      check($sformatf("refill_strobe%0d", i), 40'(bi.resultado_valido), 40'(i == 8));
    end
    check("refill_res", 40'(bi.resultado), 40'd200);
    check("reset_noerro", 40'(n_erro), 40'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
